// File: rtl/arena_pkg.sv
// Shared arena definitions: graph size, node-ID width, compass directions,
// the fixed adjacency table and the planner FSM state type.
package arena_pkg;

    localparam int unsigned NODES = 30;
    localparam int unsigned NID_W = 5;
    localparam logic [NID_W-1:0] NONE_ID = 5'd31;

    localparam logic [1:0] N = 2'd0;
    localparam logic [1:0] E = 2'd1;
    localparam logic [1:0] S = 2'd2;
    localparam logic [1:0] W = 2'd3;

    // adj[node] = '{N, E, S, W}; NONE_ID marks a missing neighbour
    localparam logic [NID_W-1:0] ADJ [NODES][4] = '{
        '{NONE_ID, 5'd1,    NONE_ID, NONE_ID},  // 0
        '{NONE_ID, 5'd29,   5'd2,    5'd0   },  // 1
        '{5'd1,    5'd8,    5'd3,    NONE_ID},  // 2
        '{5'd2,    5'd28,   5'd4,    NONE_ID},  // 3
        '{5'd3,    NONE_ID, 5'd6,    5'd5   },  // 4
        '{NONE_ID, 5'd4,    NONE_ID, NONE_ID},  // 5
        '{5'd4,    5'd7,    NONE_ID, NONE_ID},  // 6
        '{5'd8,    NONE_ID, NONE_ID, 5'd6   },  // 7
        '{5'd9,    5'd12,   5'd7,    5'd2   },  // 8
        '{5'd10,   5'd11,   5'd8,    NONE_ID},  // 9
        '{NONE_ID, NONE_ID, 5'd9,    NONE_ID},  // 10
        '{NONE_ID, NONE_ID, NONE_ID, 5'd9   },  // 11
        '{5'd13,   5'd19,   NONE_ID, 5'd8   },  // 12
        '{NONE_ID, 5'd14,   5'd12,   NONE_ID},  // 13
        '{5'd15,   5'd16,   NONE_ID, 5'd13  },  // 14
        '{NONE_ID, NONE_ID, 5'd14,   NONE_ID},  // 15
        '{5'd17,   NONE_ID, 5'd18,   5'd14  },  // 16
        '{NONE_ID, NONE_ID, 5'd16,   NONE_ID},  // 17
        '{5'd16,   NONE_ID, NONE_ID, 5'd19  },  // 18
        '{NONE_ID, 5'd18,   5'd20,   5'd12  },  // 19
        '{5'd19,   5'd21,   5'd24,   5'd29  },  // 20
        '{5'd22,   5'd23,   NONE_ID, 5'd20  },  // 21
        '{NONE_ID, NONE_ID, 5'd21,   NONE_ID},  // 22
        '{NONE_ID, NONE_ID, NONE_ID, 5'd21  },  // 23
        '{5'd20,   NONE_ID, NONE_ID, 5'd25  },  // 24
        '{NONE_ID, 5'd24,   NONE_ID, 5'd26  },  // 25
        '{5'd28,   5'd25,   5'd27,   NONE_ID},  // 26
        '{5'd26,   NONE_ID, NONE_ID, NONE_ID},  // 27
        '{5'd29,   NONE_ID, 5'd26,   5'd3   },  // 28
        '{NONE_ID, 5'd20,   5'd28,   5'd1   }   // 29
    };

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_INIT,
        S_POP,
        S_SCAN,
        S_BACKTRACK,
        S_EMIT,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/path_stream_out.sv
// Route stack filled EP-first during backtracking, then streamed SP-first
// onto path_planned/path_input with a done pulse after the last node.
module path_stream_out
    import arena_pkg::*;
(
    input  logic             clk_50M,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [NID_W-1:0] push_node,
    input  logic             emit,
    output logic [NID_W-1:0] path_planned,
    output logic             path_input,
    output logic [NID_W-1:0] path_len,
    output logic             done,
    output logic             last_c
);

    logic [NID_W-1:0] stack [NODES];
    logic [NID_W-1:0] len;
    logic [NID_W-1:0] idx;

    assign last_c = path_input && (idx == '0);

    always_ff @(posedge clk_50M) begin
        if (push) begin
            stack[len] <= push_node;
        end
    end

    // Stack is read top-down so the stream comes out SP first
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            len          <= '0;
            idx          <= '0;
            path_planned <= '0;
            path_input   <= 1'b0;
            path_len     <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                len      <= '0;
                path_len <= '0;
            end else if (push) begin
                len <= len + NID_W'(1);
            end
            if (emit) begin
                path_input   <= 1'b1;
                idx          <= len - NID_W'(1);
                path_planned <= stack[len - NID_W'(1)];
                path_len     <= len;
            end else if (path_input) begin
                if (idx == '0) begin
                    path_input   <= 1'b0;
                    path_planned <= '0;
                    done         <= 1'b1;
                end else begin
                    idx          <= idx - NID_W'(1);
                    path_planned <= stack[idx - NID_W'(1)];
                end
            end
        end
    end

endmodule

// File: rtl/path_planner_bfs.sv
// Breadth-first minimum-hop planner over the 30-node arena; the route is
// streamed SP first by path_stream_out.
module path_planner_bfs
    import arena_pkg::*;
(
    input  logic             clk_50M,
    input  logic             reset,
    input  logic             start,
    input  logic [NID_W-1:0] SP,
    input  logic [NID_W-1:0] EP,
    output logic [NID_W-1:0] path_planned,
    output logic             path_input,
    output logic [NID_W-1:0] path_len,
    output logic             busy,
    output logic             done,
    output logic             error
);

    state_t           state;
    logic             start_d;
    logic [NID_W-1:0] sp_q;
    logic [NID_W-1:0] ep_q;
    logic [NID_W-1:0] cur;
    logic [NID_W-1:0] node;
    logic [NID_W-1:0] head;
    logic [NID_W-1:0] tail;
    logic [1:0]       dir;
    logic [NODES-1:0] visited;
    logic             emit_go;
    logic [NID_W-1:0] queue  [NODES];
    logic [NID_W-1:0] parent [NODES];

    logic             launch;
    logic             push;
    logic             last_c;
    logic [NID_W-1:0] nbr;
    logic [NID_W-1:0] head_node;
    logic             nbr_new;

    assign launch    = (state == S_IDLE) && start && !start_d;
    assign push      = (state == S_BACKTRACK);
    assign nbr       = ADJ[cur][dir];
    assign head_node = queue[head];
    assign nbr_new   = (state == S_SCAN) && (nbr != NONE_ID) && !visited[nbr];

    // BFS queue and parent links need no reset: INIT rebuilds what is read
    always_ff @(posedge clk_50M) begin
        if (state == S_INIT) begin
            queue[0] <= sp_q;
        end
        if (nbr_new) begin
            queue[tail]  <= nbr;
            parent[nbr]  <= cur;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state   <= S_IDLE;
            start_d <= 1'b0;
            sp_q    <= '0;
            ep_q    <= '0;
            cur     <= '0;
            node    <= '0;
            head    <= '0;
            tail    <= '0;
            dir     <= '0;
            visited <= '0;
            emit_go <= 1'b0;
            busy    <= 1'b0;
            error   <= 1'b0;
        end else begin
            start_d <= start;
            error   <= 1'b0;
            emit_go <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        sp_q  <= SP;
                        ep_q  <= EP;
                        busy  <= 1'b1;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (sp_q >= NID_W'(NODES) || ep_q >= NID_W'(NODES)) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else begin
                        state <= S_INIT;
                    end
                end
                S_INIT: begin
                    visited <= NODES'(1) << sp_q;
                    head    <= '0;
                    tail    <= NID_W'(1);
                    state   <= S_POP;
                end
                S_POP: begin
                    if (head == tail) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else begin
                        cur  <= head_node;
                        head <= head + NID_W'(1);
                        if (head_node == ep_q) begin
                            node  <= ep_q;
                            state <= S_BACKTRACK;
                        end else begin
                            dir   <= '0;
                            state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (nbr_new) begin
                        visited[nbr] <= 1'b1;
                        tail         <= tail + NID_W'(1);
                    end
                    dir <= dir + 2'd1;
                    if (dir == W) begin
                        state <= S_POP;
                    end
                end
                S_BACKTRACK: begin
                    if (node == sp_q) begin
                        emit_go <= 1'b1;
                        state   <= S_EMIT;
                    end else begin
                        node <= parent[node];
                    end
                end
                S_EMIT: begin
                    // busy drops in the same cycle the done pulse appears
                    if (last_c) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    path_stream_out u_stream (
        .clk_50M      (clk_50M),
        .reset        (reset),
        .clear        (launch),
        .push         (push),
        .push_node    (node),
        .emit         (emit_go),
        .path_planned (path_planned),
        .path_input   (path_input),
        .path_len     (path_len),
        .done         (done),
        .last_c       (last_c)
    );

endmodule

// File: tb/tb_path_planner_bfs.sv
// Scoreboard bench for path_planner_bfs: stimulus queues expected route nodes
// and end events, a negedge monitor pops and compares them.
module tb_path_planner_bfs;

    logic       clk_50M = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] SP;
    logic [4:0] EP;
    logic [4:0] path_planned;
    logic       path_input;
    logic [4:0] path_len;
    logic       busy;
    logic       done;
    logic       error;

    always #10 clk_50M = ~clk_50M;

    path_planner_bfs dut (
        .clk_50M      (clk_50M),
        .reset        (reset),
        .start        (start),
        .SP           (SP),
        .EP           (EP),
        .path_planned (path_planned),
        .path_input   (path_input),
        .path_len     (path_len),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    localparam logic [1:0] K_NODE = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [4:0] node;
        logic [4:0] len;
    } exp_t;

    exp_t exp_q[$];
    int   total     = 0;
    int   bad       = 0;
    int   node_seen = 0;
    int   done_seen = 0;
    int   err_seen  = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every node, done or error the DUT presents must match the queue head
    always @(negedge clk_50M) begin
        exp_t e;
        int   act_kind;
        if (!reset && (path_input || done || error)) begin
            check("one_event_per_cycle", int'(path_input) + int'(done) + int'(error), 1);
            act_kind = path_input ? 0 : (done ? 1 : 2);
            if (path_input) node_seen++;
            if (done)       done_seen++;
            if (error)      err_seen++;
            check("expectation_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("event_kind", act_kind, int'(e.kind));
                if (e.kind == K_NODE) begin
                    check("path_planned", int'(path_planned), int'(e.node));
                    check("path_len", int'(path_len), int'(e.len));
                end else begin
                    check("busy_at_end", int'(busy), 0);
                end
            end
        end
    end

    task automatic push_exp(input logic [1:0] kind, input logic [4:0] nd, input logic [4:0] ln);
        exp_t e;
        e.kind = kind;
        e.node = nd;
        e.len  = ln;
        exp_q.push_back(e);
    endtask

    task automatic launch(input logic [4:0] sp, input logic [4:0] ep);
        @(posedge clk_50M); #1;
        SP    = sp;
        EP    = ep;
        start = 1'b1;
    endtask

    task automatic wait_end(output int cyc);
        cyc = 1;
        while (!(done || error) && cyc < 400) begin
            @(posedge clk_50M); #1;
            cyc++;
        end
        check("end_event_seen", int'(done || error), 1);
    endtask

    // r holds the route, first node in the low 5 bits; n==0 means an error is expected
    task automatic run_case(input logic [4:0] sp, input logic [4:0] ep,
                            input int n, input logic [59:0] r, input int hold);
        int cyc;
        int d0;
        int n0;
        d0 = done_seen;
        n0 = node_seen;
        if (n == 0) begin
            push_exp(K_ERR, 5'd0, 5'd0);
        end else begin
            for (int i = 0; i < n; i++) push_exp(K_NODE, r[5*i +: 5], 5'(n));
            push_exp(K_DONE, 5'd0, 5'd0);
        end
        launch(sp, ep);
        @(posedge clk_50M); #1;
        check("busy_after_launch", int'(busy), 1);
        wait_end(cyc);
        if (n == 0) check("err_latency_le_3", int'(cyc <= 3), 1);
        else        check("latency_le_214", int'(cyc <= 214), 1);
        repeat (hold) @(posedge clk_50M);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk_50M);
        #1;
        check("busy_idle", int'(busy), 0);
        check("nodes_streamed", node_seen - n0, n);
        check("done_count", done_seen - d0, (n == 0) ? 0 : 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_path_planned"}, int'(path_planned), 0);
        check({tag, "_path_input"}, int'(path_input), 0);
        check({tag, "_path_len"}, int'(path_len), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_error"}, int'(error), 0);
    endtask

    initial begin
        int cyc;
        int d0;
        int n0;
        int e0;
        reset = 1'b1;
        start = 1'b0;
        SP    = 5'd0;
        EP    = 5'd0;
        repeat (3) @(posedge clk_50M);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;

        run_case(5'd0,  5'd20, 4, {5'd20, 5'd29, 5'd1, 5'd0}, 0);
        run_case(5'd0,  5'd7,  5, {5'd7, 5'd8, 5'd2, 5'd1, 5'd0}, 0);
        run_case(5'd5,  5'd5,  1, {5'd5}, 0);
        run_case(5'd29, 5'd0,  3, {5'd0, 5'd1, 5'd29}, 0);
        run_case(5'd10, 5'd27, 8, {5'd27, 5'd26, 5'd28, 5'd3, 5'd2, 5'd8, 5'd9, 5'd10}, 0);
        // equal-length routes exist; N,E,S,W order picks the one through 8 and 12
        run_case(5'd3,  5'd19, 5, {5'd19, 5'd12, 5'd8, 5'd2, 5'd3}, 0);

        e0 = err_seen;
        run_case(5'd0,  5'd30, 0, 60'd0, 0);
        run_case(5'd31, 5'd4,  0, 60'd0, 0);
        check("error_count", err_seen - e0, 2);

        // Reset in the middle of a search aborts with no partial stream
        n0 = node_seen;
        launch(5'd0, 5'd20);
        @(posedge clk_50M); #1;
        start = 1'b0;
        repeat (4) @(posedge clk_50M);
        #1;
        check("busy_before_abort", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk_50M); #1;
        check_outputs_zero("abort");
        reset = 1'b0;
        repeat (3) @(posedge clk_50M);
        #1;
        check("no_stream_after_abort", node_seen - n0, 0);
        run_case(5'd20, 5'd0, 4, {5'd0, 5'd1, 5'd29, 5'd20}, 0);

        // Held-high start must not relaunch
        run_case(5'd0, 5'd7, 5, {5'd7, 5'd8, 5'd2, 5'd1, 5'd0}, 500);

        // A second edge while busy is ignored
        d0 = done_seen;
        n0 = node_seen;
        for (int i = 0; i < 5; i++) push_exp(K_NODE, 5'd0, 5'd5);
        exp_q[1].node = 5'd1;
        exp_q[2].node = 5'd2;
        exp_q[3].node = 5'd8;
        exp_q[4].node = 5'd7;
        push_exp(K_DONE, 5'd0, 5'd0);
        launch(5'd0, 5'd7);
        repeat (3) @(posedge clk_50M);
        #1;
        start = 1'b0;
        @(posedge clk_50M); #1;
        SP    = 5'd5;
        EP    = 5'd5;
        start = 1'b1;
        wait_end(cyc);
        check("busy_edge_latency", int'(cyc <= 214), 1);
        repeat (40) @(posedge clk_50M);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk_50M);
        #1;
        check("busy_edge_nodes", node_seen - n0, 5);
        check("busy_edge_done", done_seen - d0, 1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/path_planner_bfs.md
Name: path_planner_bfs

Overview:
- Breadth-first shortest-path planner over the fixed 30-node arena graph.
- Takes a start node (SP) and an end node (EP) plus a start strobe, and computes the minimum-hop route.
- Streams the route one node per cycle, SP first, onto path_planned/path_input.
- Sits directly upstream of the path-mapping stage, which consumes that stream and converts it to turn flags; SP/EP/start come from the CPU/mapping side.

Parameters:
- NODES, 30, number of graph nodes; valid IDs are 0..NODES-1.
- NID_W, 5, node-ID width.
- NONE_ID, 31, adjacency sentinel meaning "no neighbour".

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level request; a rising edge launches planning.
- SP  in  5  start node, sampled on the start rising edge.
- EP  in  5  end node, sampled on the start rising edge.
- path_planned  out  5  route node ID, valid while path_input=1.
- path_input  out  1  node-valid strobe; high for exactly path_len consecutive cycles.
- path_len  out  5  node count of the route including SP and EP; valid from the first path_input cycle until the next launch.
- busy  out  1  high from launch until done/error.
- done  out  1  one-cycle pulse, the cycle after the last node.
- error  out  1  one-cycle pulse: bad ID or EP unreachable.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, start edge detector cleared. A reset asserted mid-operation aborts immediately; the next cycle is IDLE with no partial stream.
- Launch: in IDLE, start=1 with start_d=0 captures SP/EP and sets busy=1. Start edges while busy are ignored. A held-high start does not relaunch.
- States: IDLE -> CHECK -> INIT -> POP <-> SCAN -> BACKTRACK -> EMIT -> DONE -> IDLE. ERR -> IDLE.
- CHECK: if SP>=NODES or EP>=NODES, go to ERR; otherwise go to INIT.
- INIT (1 cycle):
  - visited vector = one-hot(SP).
  - queue[0] = SP; head = 0; tail = 1.
- POP:
  - If head==tail, go to ERR.
  - Otherwise cur = queue[head]; head++.
  - If cur==EP, go to BACKTRACK with node = EP, len = 0.
  - Otherwise go to SCAN with dir = 0.
- SCAN (4 cycles per node; dir order N, E, S, W):
  - n = adj[cur][dir].
  - If n!=NONE_ID and !visited[n]: set visited[n], parent[n] = cur, queue[tail] = n, tail++.
  - After dir==3, go to POP.
- BACKTRACK (1 cycle per node):
  - stack[len] = node; len++.
  - If node==SP, go to EMIT. Otherwise node = parent[node].
- EMIT: drive path_planned = stack[idx] from idx = len-1 down to 0, one per cycle, with path_input=1. path_len = len.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- ERR: error=1 and busy=0 for one cycle; path_input is never asserted; then IDLE.
- Tie-break: the N, E, S, W scan order is normative. Among equal-length routes the emitted one is deterministic.
- Widths: head/tail/len/idx are 5-bit; the queue holds at most NODES entries and never wraps.
- SP==EP: route is the single node SP, path_len = 1.
- Worst-case launch-to-done latency: 3 + 30*(1+4) + 30 + 30 + 1 = 214 cycles. The bench checks latency is at most 214.

Decomposition:
- Shared package (arena_pkg) holds:
  - NODES, NID_W, NONE_ID.
  - Direction constants N=0, E=1, S=2, W=3.
  - The adjacency constant adj[30][4].
- Undirected edge set:
  - 0-1, 1-2, 1-29, 2-3, 2-8, 3-4, 3-28, 4-5, 4-6, 6-7, 7-8, 8-9, 8-12, 9-10, 9-11
  - 12-13, 12-19, 13-14, 14-15, 14-16, 16-17, 16-18, 18-19, 19-20, 20-21, 20-24, 20-29, 21-22, 21-23, 24-25, 25-26, 26-27, 26-28, 28-29
- Directional placement of each edge follows the arena compass map already held in the package.
- Sub-module: path_stream_out (stack plus EMIT counter driving path_planned/path_input/done) is natural. The BFS core stays in the top.

Test Plan:
- SP=0, EP=20, start rising -> path_input high 4 cycles with nodes 0, 1, 29, 20; path_len=4; done pulse the next cycle.
- SP=0, EP=7 -> stream 0, 1, 2, 8, 7; path_len=5; busy low after done.
- SP=5, EP=5 -> single cycle path_planned=5; path_len=1; done.
- SP=0, EP=30 -> error pulse 3 cycles after the edge; path_input never high; busy=0 afterwards.
- Launch SP=0, EP=20; assert reset for 1 cycle during SCAN -> all outputs 0 next cycle. A subsequent launch SP=20, EP=0 streams 20, 29, 1, 0.
- start held high for 500 cycles after one route -> exactly one route emitted. A second start edge while busy -> ignored, and the single route still streams correctly.
